// File: rtl/perceptron_seq_ctrl_pkg.sv
// Shared types and the fixed MAC schedule for the 2-2-3-1 perceptron sequencer.
// Each step entry gives the operand A source, the weight index, the destination and clear-vs-accumulate.
package perceptron_pkg;

  localparam int NUM_W = 13;

  typedef logic [3:0] step_t;

  localparam step_t LAST_STEP = 4'd12;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef enum logic [2:0] {
    OPA_X1, OPA_X2, OPA_V11, OPA_V12, OPA_V21, OPA_V22, OPA_V23
  } opa_t;

  typedef enum logic [2:0] {
    DST_V11, DST_V12, DST_V21, DST_V22, DST_V23, DST_Y
  } dst_t;

  typedef struct packed {
    opa_t  opa;
    step_t widx;
    dst_t  dst;
    logic  clr;
  } step_info_t;

  function automatic step_info_t step_info(input step_t s);
    step_info_t r;
    r = '{OPA_X1, 4'd0, DST_V11, 1'b1};
    case (s)
      4'd0:    r = '{OPA_X1,  4'd0,  DST_V11, 1'b1};
      4'd1:    r = '{OPA_X2,  4'd2,  DST_V11, 1'b0};
      4'd2:    r = '{OPA_X1,  4'd1,  DST_V12, 1'b1};
      4'd3:    r = '{OPA_X2,  4'd3,  DST_V12, 1'b0};
      4'd4:    r = '{OPA_V11, 4'd4,  DST_V21, 1'b1};
      4'd5:    r = '{OPA_V12, 4'd5,  DST_V21, 1'b0};
      4'd6:    r = '{OPA_V11, 4'd6,  DST_V22, 1'b1};
      4'd7:    r = '{OPA_V12, 4'd7,  DST_V22, 1'b0};
      4'd8:    r = '{OPA_V11, 4'd8,  DST_V23, 1'b1};
      4'd9:    r = '{OPA_V12, 4'd9,  DST_V23, 1'b0};
      4'd10:   r = '{OPA_V21, 4'd10, DST_Y,   1'b1};
      4'd11:   r = '{OPA_V22, 4'd11, DST_Y,   1'b0};
      4'd12:   r = '{OPA_V23, 4'd12, DST_Y,   1'b0};
      default: r = '{OPA_X1,  4'd0,  DST_V11, 1'b1};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/perceptron_seq_ctrl_if.sv
// Config, input and output handshake bundle for the perceptron sequencer.
interface perceptron_seq_ctrl_if #(
  parameter int DW = 8,
  parameter int AW = 16
);
  logic                 cfg_we;
  logic [3:0]           cfg_addr;
  logic signed [DW-1:0] cfg_wdata;
  logic                 cfg_err;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_x1;
  logic signed [DW-1:0] in_x2;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [AW-1:0] out_y;
  logic                 out_p;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, in_valid, in_x1, in_x2, out_ready,
    input  cfg_err, in_ready, out_valid, out_y, out_p
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, in_valid, in_x1, in_x2, out_ready,
    output cfg_err, in_ready, out_valid, out_y, out_p
  );
endinterface

// File: rtl/perceptron_seq_ctrl_mac.sv
// Registered signed multiply-add: acc <= (clr ? 0 : acc) + a * w, wrapping modulo 2^AW.
module perceptron_mac #(
  parameter int DW = 8,
  parameter int AW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  input  logic                 i_clr,
  input  logic signed [AW-1:0] i_a,
  input  logic signed [DW-1:0] i_w,
  output logic signed [AW-1:0] o_acc
);

  logic signed [AW-1:0] w_w_ext;
  logic signed [AW-1:0] w_prod;
  logic signed [AW-1:0] r_acc;

  // Only the low AW bits of the product matter since everything wraps at AW.
  assign w_w_ext = {{(AW-DW){i_w[DW-1]}}, i_w};
  assign w_prod  = i_a * w_w_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= i_clr ? w_prod : r_acc + w_prod;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/perceptron_seq_ctrl.sv
// Time-multiplexed 2-2-3-1 perceptron evaluator on one shared MAC, thirteen steps per input pair.
//   state | meaning
//   IDLE  | ready for an input pair; weight writes allowed
//   RUN   | stepping the MAC schedule 0..12
//   DONE  | result presented, waiting for out_ready
module perceptron_seq_ctrl
  import perceptron_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 16
) (
  input  logic               clk,
  input  logic               rst,
  perceptron_seq_ctrl_if.slave bus
);

  state_t               r_state;
  step_t                r_step;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic                 r_cfg_err;
  logic signed [DW-1:0] r_x1;
  logic signed [DW-1:0] r_x2;
  logic signed [DW-1:0] r_w [NUM_W];
  logic signed [AW-1:0] r_v11, r_v12, r_v21, r_v22, r_v23;

  step_info_t           w_cur;
  step_info_t           w_prev;
  logic signed [AW-1:0] w_opa;
  logic signed [DW-1:0] w_wsel;
  logic signed [AW-1:0] w_acc;
  logic                 w_run;
  logic                 w_cfg_ok;

  assign w_cur    = step_info(r_step);
  assign w_prev   = step_info(r_step - 4'd1);
  assign w_run    = (r_state == RUN);
  assign w_cfg_ok = (r_state == IDLE) && (bus.cfg_addr <= LAST_STEP);
  assign w_wsel   = r_w[w_cur.widx];

  always_comb begin
    w_opa = '0;
    case (w_cur.opa)
      OPA_X1:  w_opa = {{(AW-DW){r_x1[DW-1]}}, r_x1};
      OPA_X2:  w_opa = {{(AW-DW){r_x2[DW-1]}}, r_x2};
      OPA_V11: w_opa = r_v11;
      OPA_V12: w_opa = r_v12;
      OPA_V21: w_opa = r_v21;
      OPA_V22: w_opa = r_v22;
      OPA_V23: w_opa = r_v23;
      default: w_opa = '0;
    endcase
  end

  perceptron_mac #(.DW(DW), .AW(AW)) u_mac (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_run),
    .i_clr (w_cur.clr),
    .i_a   (w_opa),
    .i_w   (w_wsel),
    .o_acc (w_acc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_step      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_x1        <= '0;
      r_x2        <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_state    <= RUN;
            r_step     <= '0;
            r_x1       <= bus.in_x1;
            r_x2       <= bus.in_x2;
            r_in_ready <= 1'b0;
          end
        end
        RUN: begin
          if (r_step == LAST_STEP) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_step <= r_step + 4'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // A clearing step means the accumulator still holds the previous step's finished intermediate.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v11 <= '0;
      r_v12 <= '0;
      r_v21 <= '0;
      r_v22 <= '0;
      r_v23 <= '0;
    end else if (w_run && w_cur.clr && (r_step != 4'd0)) begin
      case (w_prev.dst)
        DST_V11: r_v11 <= w_acc;
        DST_V12: r_v12 <= w_acc;
        DST_V21: r_v21 <= w_acc;
        DST_V22: r_v22 <= w_acc;
        DST_V23: r_v23 <= w_acc;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_W; i++) r_w[i] <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      if (bus.cfg_we && w_cfg_ok) r_w[bus.cfg_addr] <= bus.cfg_wdata;
      r_cfg_err <= bus.cfg_we && !w_cfg_ok;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.cfg_err   = r_cfg_err;
  assign bus.out_y     = w_acc;
  assign bus.out_p     = !w_acc[AW-1] && (w_acc != '0);

endmodule

// File: tb/tb_perceptron_seq_ctrl.sv
// Directed and randomized checks of the perceptron sequencer against a plain-arithmetic network model.
module tb_perceptron_seq_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  perceptron_seq_ctrl_if #(.DW(8), .AW(16)) bus ();
  perceptron_seq_ctrl #(.DW(8), .AW(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  logic signed [7:0] wm [13];
  logic signed [7:0] cx1, cx2;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic signed [15:0] wr(input longint v);
    logic signed [15:0] r;
    r = v[15:0];
    return r;
  endfunction

  function automatic logic signed [15:0] model(input logic signed [7:0] x1, input logic signed [7:0] x2);
    logic signed [15:0] v11, v12, v21, v22, v23;
    v11 = wr(longint'(x1) * wm[0] + longint'(x2) * wm[2]);
    v12 = wr(longint'(x1) * wm[1] + longint'(x2) * wm[3]);
    v21 = wr(longint'(v11) * wm[4] + longint'(v12) * wm[5]);
    v22 = wr(longint'(v11) * wm[6] + longint'(v12) * wm[7]);
    v23 = wr(longint'(v11) * wm[8] + longint'(v12) * wm[9]);
    return wr(longint'(v21) * wm[10] + longint'(v22) * wm[11] + longint'(v23) * wm[12]);
  endfunction

  task automatic cfg_wr(input int a, input int d, input bit exp_err, input string tag);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = 4'(a);
    bus.cfg_wdata = 8'(d);
    tick();
    bus.cfg_we = 1'b0;
    chk(tag, int'(bus.cfg_err), int'(exp_err));
    if (!exp_err) wm[a] = 8'(d);
  endtask

  task automatic start(input logic signed [7:0] x1, input logic signed [7:0] x2);
    chk("ready_before_accept", int'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_x1    = x1;
    bus.in_x2    = x2;
    tick();
    bus.in_valid = 1'b0;
    acc_cyc = cyc;
    cx1 = x1;
    cx2 = x2;
    chk("ready_after_accept", int'(bus.in_ready), 0);
  endtask

  task automatic finish(input string tag, input int hold);
    int guard;
    logic signed [15:0] ey;
    logic signed [15:0] y0;
    logic p0;
    guard = 0;
    while (!bus.out_valid && guard < 40) begin
      tick();
      guard++;
    end
    chk({tag, "_latency"}, cyc - acc_cyc, 13);
    ey = model(cx1, cx2);
    chk({tag, "_y"}, int'(bus.out_y), int'(ey));
    chk({tag, "_p"}, int'(bus.out_p), int'(ey > 16'sd0));
    y0 = bus.out_y;
    p0 = bus.out_p;
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.in_x1    = 8'($urandom);
      bus.in_x2    = 8'($urandom);
      tick();
      chk({tag, "_hold_y"}, int'(bus.out_y), int'(y0));
      chk({tag, "_hold_p"}, int'(bus.out_p), int'(p0));
      chk({tag, "_hold_valid"}, int'(bus.out_valid), 1);
      chk({tag, "_hold_ready"}, int'(bus.in_ready), 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, "_taken"}, int'(bus.out_valid), 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
    bus.in_valid = 1'b0; bus.in_x1 = '0; bus.in_x2 = '0; bus.out_ready = 1'b0;
    for (int i = 0; i < 13; i++) wm[i] = '0;
    repeat (3) tick();
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_y", int'(bus.out_y), 0);
    chk("rst_out_p", int'(bus.out_p), 0);
    chk("rst_cfg_err", int'(bus.cfg_err), 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 13; i++) cfg_wr(i, 1, 1'b0, "cfg_ok");
    start(8'sd1, 8'sd1);
    finish("t1_ones", 0);
    start(-8'sd1, 8'sd0);
    finish("t2_neg", 0);
    start(8'sd0, 8'sd0);
    finish("t2_zero", 0);

    cfg_wr(0, 2, 1'b0, "cfg_w0");
    cfg_wr(1, -3, 1'b0, "cfg_w1");
    start(8'sd3, 8'sd4);
    finish("t3_mixed", 0);

    start(8'sd5, -8'sd2);
    finish("t4_hold", 5);

    start(8'sd2, 8'sd3);
    tick();
    tick();
    cfg_wr(0, 9, 1'b1, "t5_err_run");
    tick();
    chk("t5_err_one_cycle", int'(bus.cfg_err), 0);
    finish("t5_old_w0", 0);
    cfg_wr(13, 7, 1'b1, "t5_err_addr13");
    start(8'sd1, -8'sd1);
    finish("t5_after_addr13", 0);

    bus.cfg_we = 1'b1; bus.cfg_addr = 4'd12; bus.cfg_wdata = -8'sd4;
    bus.in_valid = 1'b1; bus.in_x1 = 8'sd6; bus.in_x2 = -8'sd3;
    tick();
    bus.cfg_we = 1'b0; bus.in_valid = 1'b0;
    wm[12] = -8'sd4;
    acc_cyc = cyc; cx1 = 8'sd6; cx2 = -8'sd3;
    chk("same_edge_no_err", int'(bus.cfg_err), 0);
    finish("same_edge", 0);

    start(8'sd7, 8'sd7);
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 13; i++) wm[i] = '0;
    chk("t6_in_ready", int'(bus.in_ready), 1);
    chk("t6_out_valid", int'(bus.out_valid), 0);
    chk("t6_out_y", int'(bus.out_y), 0);
    start(8'($urandom), 8'($urandom));
    finish("t6_zero_w", 0);

    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < 13; i++) cfg_wr(i, int'($urandom_range(0, 255)) - 128, 1'b0, "rnd_cfg");
      start(8'($urandom), 8'($urandom));
      finish("rnd", int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
